// File: rtl/layer_controller_start_pio_if.sv
// Avalon-MM slave bus bundle for the layer controller start PIO.
// The interconnect side uses the master modport and the PIO uses the slave modport.
interface layer_controller_start_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/layer_controller_start_pio.sv
// Start/done PIO for the FFNN layer controller.
//   addr0 DATA   : level start bits, read/write
//   addr1 PULSE  : write-1-to-start pulses of PULSE_CYCLES clocks; reads pulses in flight
//   addr2 STATUS : sticky rising-edge capture of done_in; write-1-to-clear
//   addr3 MASK   : irq enable per channel (only with LAYER_CTRL_START_PIO_IRQ_EN)
// Optional feature macro: LAYER_CTRL_START_PIO_IRQ_EN (undefined: no mask, irq tied low).
module layer_controller_start_pio #(
  parameter int              WIDTH        = 4,
  parameter int              PULSE_CYCLES = 1,
  parameter logic [WIDTH-1:0] DATA_RESET  = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  layer_controller_start_pio_if.slave bus,
  output logic [WIDTH-1:0]            out_port,
  input  logic [WIDTH-1:0]            done_in,
  output logic                        irq
);

  localparam int               CNT_W    = $clog2(PULSE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] pulse_q;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] capture_q;
  logic [WIDTH-1:0] done_prev;
  logic [WIDTH-1:0] mask_rd;
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             wr_data;
  logic             wr_pulse;
  logic             wr_status;
  logic             unused_wdata;

  // Writedata bits above WIDTH-1 are deliberately ignored.
  assign unused_wdata = ^bus.writedata;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_data   = wr & (bus.address == 2'd0);
  assign wr_pulse  = wr & (bus.address == 2'd1);
  assign wr_status = wr & (bus.address == 2'd2);
  assign wdata     = bus.writedata[WIDTH-1:0];

  assign rise = done_in & ~done_prev;
  assign clr  = wr_status ? wdata : '0;

  assign out_port = data_q | pulse_q;

  // Level start register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= DATA_RESET;
    end else if (wr_data) begin
      data_q <= wdata;
    end
  end

  // Per-channel pulse generators; a new write reloads the counter so a retrigger extends without a gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_pulse && wdata[i]) begin
          pulse_q[i] <= 1'b1;
          cnt[i]     <= CNT_LOAD;
        end else if (pulse_q[i]) begin
          if (cnt[i] == '0) pulse_q[i] <= 1'b0;
          else              cnt[i]     <= cnt[i] - 1'b1;
        end
      end
    end
  end

  // Sticky done-edge capture; a simultaneous edge wins over a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_prev <= '0;
      capture_q <= '0;
    end else begin
      done_prev <= done_in;
      capture_q <= (capture_q & ~clr) | rise;
    end
  end

`ifdef LAYER_CTRL_START_PIO_IRQ_EN
  logic [WIDTH-1:0] mask_q;
  logic             irq_q;
  logic             wr_mask;

  assign wr_mask = wr & (bus.address == 2'd3);
  assign mask_rd = mask_q;
  assign irq     = irq_q;

  // Interrupt mask register and registered interrupt level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_mask) mask_q <= wdata;
      irq_q <= |(capture_q & mask_q);
    end
  end
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  // Zero-wait-state read mux, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux = data_q;
      2'd1:    rd_mux = pulse_q;
      2'd2:    rd_mux = capture_q;
      default: rd_mux = mask_rd;
    endcase
    bus.readdata = 32'(rd_mux);
  end

endmodule

// File: tb/tb_layer_controller_start_pio.sv
// Self-checking bench for layer_controller_start_pio (WIDTH=4, PULSE_CYCLES=3, DATA_RESET=0).
// Builds with or without LAYER_CTRL_START_PIO_IRQ_EN.
module tb_layer_controller_start_pio;

  localparam int W  = 4;
  localparam int PC = 3;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] out_port;
  logic [W-1:0] done_in;
  logic         irq;

  layer_controller_start_pio_if bus ();

  layer_controller_start_pio #(
    .WIDTH(W), .PULSE_CYCLES(PC), .DATA_RESET(4'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .out_port(out_port), .done_in(done_in), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pulse channels tracked as remaining high cycles.
  logic [W-1:0] m_data, m_cap, m_prev, m_mask;
  logic         m_irq;
  int           m_rem [W];

  logic [31:0]  last_rd;
  logic [W-1:0] last_out;
  logic         last_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_pulse();
    logic [W-1:0] p;
    for (int i = 0; i < W; i++) p[i] = (m_rem[i] > 0);
    return p;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_data);
      2'd1:    return 32'(m_pulse());
      2'd2:    return 32'(m_cap);
      default: return 32'(m_mask);
    endcase
  endfunction

  task automatic model_reset();
    m_data = '0; m_cap = '0; m_prev = '0; m_mask = '0; m_irq = 1'b0;
    for (int i = 0; i < W; i++) m_rem[i] = 0;
  endtask

  task automatic model_update();
    logic         wr;
    logic [W-1:0] wd;
    logic         nirq;
    wr   = bus.chipselect & ~bus.write_n;
    wd   = bus.writedata[W-1:0];
    nirq = |(m_cap & m_mask);
    if (wr && bus.address == 2'd2) m_cap = m_cap & ~wd;
    m_cap  = m_cap | (done_in & ~m_prev);
    m_prev = done_in;
    if (wr && bus.address == 2'd0) m_data = wd;
`ifdef LAYER_CTRL_START_PIO_IRQ_EN
    if (wr && bus.address == 2'd3) m_mask = wd;
`endif
    for (int i = 0; i < W; i++) begin
      if (wr && bus.address == 2'd1 && wd[i]) m_rem[i] = PC;
      else if (m_rem[i] > 0)                  m_rem[i] = m_rem[i] - 1;
    end
    m_irq = nirq;
  endtask

  // One bus cycle: drive, compare against the model before the edge, clock, advance the model.
  task automatic cyc(input logic [1:0] a, input logic cs, input logic wn,
                     input logic [31:0] wd, input logic [W-1:0] d);
    bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = wd; done_in = d;
    #1;
    last_rd = bus.readdata; last_out = out_port; last_irq = irq;
    check("model_readdata", last_rd, m_read(a));
    check("model_out_port", 32'(last_out), 32'(m_data | m_pulse()));
    check("model_irq", 32'(last_irq), 32'(m_irq));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd, input logic [W-1:0] d);
    cyc(a, 1'b1, 1'b0, wd, d);
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [W-1:0] d);
    cyc(a, 1'b1, 1'b1, 32'h0, d);
  endtask

  task automatic idle_bus();
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
  endtask

  typedef struct {
    logic [1:0]   addr;
    logic         wr;
    logic [31:0]  wd;
    logic [W-1:0] done;
    logic [31:0]  exp_rd;
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t vecs [7];
  int   high_cnt;
  logic [W-1:0] rdone;

  initial begin
    idle_bus();
    done_in = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Register access vectors; exp_rd/exp_out are the pre-edge values of each cycle.
    vecs[0] = '{2'd0, 1'b0, 32'h0,        4'h0, 32'h0, 4'h0};
    vecs[1] = '{2'd0, 1'b1, 32'h5,        4'h0, 32'h0, 4'h0};
    vecs[2] = '{2'd0, 1'b0, 32'h0,        4'h0, 32'h5, 4'h5};
    vecs[3] = '{2'd0, 1'b1, 32'hFFFFFFF0, 4'h0, 32'h5, 4'h5};
    vecs[4] = '{2'd0, 1'b0, 32'h0,        4'h0, 32'h0, 4'h0};
    vecs[5] = '{2'd1, 1'b0, 32'h0,        4'h0, 32'h0, 4'h0};
    vecs[6] = '{2'd2, 1'b0, 32'h0,        4'h0, 32'h0, 4'h0};
    for (int i = 0; i < 7; i++) begin
      cyc(vecs[i].addr, 1'b1, ~vecs[i].wr, vecs[i].wd, vecs[i].done);
      check($sformatf("vec%0d_rd", i), last_rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_out", i), 32'(last_out), 32'(vecs[i].exp_out));
    end

    // Single pulse: high for exactly PC cycles.
    wr_reg(2'd1, 32'h2, 4'h0);
    high_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      rd_reg(2'd1, 4'h0);
      if (last_out[1]) begin
        high_cnt++;
        check("pulse_rd_busy", last_rd, 32'h2);
      end
    end
    check("pulse_high_cycles", high_cnt, PC);
    check("pulse_rd_after", last_rd, 32'h0);

    // Retrigger during the second high cycle: 5 high cycles total, no gap.
    wr_reg(2'd1, 32'h2, 4'h0);
    high_cnt = 0;
    rd_reg(2'd1, 4'h0);
    if (last_out[1]) high_cnt++;
    wr_reg(2'd1, 32'h2, 4'h0);
    if (last_out[1]) high_cnt++;
    for (int i = 0; i < 6; i++) begin
      rd_reg(2'd1, 4'h0);
      if (last_out[1]) high_cnt++;
    end
    check("retrigger_high_cycles", high_cnt, 5);

    // Level ORed with pulse: expiry leaves the level bit high.
    wr_reg(2'd0, 32'h2, 4'h0);
    wr_reg(2'd1, 32'h2, 4'h0);
    for (int i = 0; i < 5; i++) rd_reg(2'd0, 4'h0);
    check("level_or_pulse", 32'(last_out), 32'h2);
    wr_reg(2'd0, 32'h0, 4'h0);

    // Edge capture on done_in[3], sticky while held.
    rd_reg(2'd2, 4'h8);
    rd_reg(2'd2, 4'h8);
    check("cap_first", last_rd, 32'h8);
    rd_reg(2'd2, 4'h8);
    check("cap_sticky", last_rd, 32'h8);
    rd_reg(2'd2, 4'h0);
    wr_reg(2'd2, 32'h8, 4'h8);
    rd_reg(2'd2, 4'h8);
    check("cap_set_wins", last_rd, 32'h8);
    wr_reg(2'd2, 32'h8, 4'h8);
    rd_reg(2'd2, 4'h8);
    check("cap_w1c", last_rd, 32'h0);

`ifdef LAYER_CTRL_START_PIO_IRQ_EN
    wr_reg(2'd3, 32'h8, 4'h0);
    rd_reg(2'd3, 4'h8);
    check("mask_rd", last_rd, 32'h8);
    rd_reg(2'd2, 4'h8);
    check("irq_lag", 32'(last_irq), 32'h0);
    rd_reg(2'd2, 4'h8);
    check("irq_set", 32'(last_irq), 32'h1);
    wr_reg(2'd3, 32'h0, 4'h8);
    rd_reg(2'd2, 4'h8);
    rd_reg(2'd2, 4'h8);
    check("irq_mask_clear", 32'(last_irq), 32'h0);
    wr_reg(2'd2, 32'hF, 4'h0);
    wr_reg(2'd3, 32'h8, 4'h0);
    rd_reg(2'd2, 4'h1);
    rd_reg(2'd2, 4'h1);
    rd_reg(2'd2, 4'h1);
    check("irq_unmasked_bit", 32'(last_irq), 32'h0);
    check("irq_cap0", last_rd, 32'h1);
    wr_reg(2'd3, 32'h0, 4'h0);
`else
    wr_reg(2'd3, 32'hF, 4'h0);
    rd_reg(2'd3, 4'h1);
    check("noirq_mask_rd", last_rd, 32'h0);
    rd_reg(2'd2, 4'h1);
    check("noirq_cap", last_rd, 32'h1);
    rd_reg(2'd2, 4'h1);
    check("noirq_irq", 32'(last_irq), 32'h0);
`endif
    wr_reg(2'd2, 32'hF, 4'h0);

    // Asynchronous reset in the middle of a pulse with the level set.
    wr_reg(2'd0, 32'h5, 4'h0);
    wr_reg(2'd1, 32'hA, 4'h0);
    idle_bus();
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_out_port", 32'(out_port), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    for (int a = 0; a < 3; a++) begin
      bus.address = 2'(a);
      #1;
      check($sformatf("rst_rd_addr%0d", a), bus.readdata, 32'h0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Randomized traffic against the model.
    rdone = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) rdone = rdone ^ 4'($urandom);
      cyc(2'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 2) != 0),
          $urandom, rdone);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_controller_start_pio.md
Name: layer_controller_start_pio

Overview:
Parametrised Avalon-MM slave PIO that drives per-neuron/per-layer start lines for the FFNN layer controller.
- Level mode: software holds a bit high.
- Pulse mode: the block raises a bit for exactly PULSE_CYCLES clocks, then clears it itself.
- Captures rising edges of per-channel done inputs into a sticky status register, with optional masked interrupt.
- Sits between the Nios/Avalon interconnect and the neuron datapath start/done handshake.

Parameters:
WIDTH, 4, number of start/done channels (1..32)
PULSE_CYCLES, 1, high time of a pulse-mode start in clocks (1..255)
DATA_RESET, 0, reset value of the DATA register (WIDTH bits)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above WIDTH-1 ignored
readdata  out  32  combinational read data, zero-extended above WIDTH-1
out_port  out  WIDTH  start lines = data_q | pulse_q
done_in  in  WIDTH  per-channel done; synchronous to clk
irq  out  1  interrupt, level, active high

Behaviour:
- Reset, asynchronous on reset_n low:
  - data_q=DATA_RESET; pulse_q=0; all pulse counters=0; capture_q=0; done_prev=0; mask_q=0.
  - Resulting outputs: out_port=DATA_RESET; irq=0.
- Write strobe: wr = chipselect & ~write_n. Reads have zero wait states and no side effects.
- Register map:
  - addr0 DATA (RW): wr loads data_q<=writedata[WIDTH-1:0]; read returns data_q.
  - addr1 PULSE (W1S):
    - For each bit i with writedata[i]=1: pulse_q[i]<=1 and cnt[i]<=PULSE_CYCLES-1.
    - Bits written 0 are unaffected.
    - Read returns pulse_q (pulses in flight).
  - addr2 STATUS (W1C):
    - Read returns capture_q.
    - A write clears capture_q[i] wherever writedata[i]=1.
  - addr3 MASK (RW, see Optional Feature): irq enable per channel.
- Pulse timing, per channel, with an independent counter of width clog2(PULSE_CYCLES)+1:
  - A PULSE write sampled at edge N gives pulse_q[i]=1 from edge N to edge N+PULSE_CYCLES.
  - The bit is therefore high for exactly PULSE_CYCLES cycles.
  - Each cycle while pulse_q[i]=1: if cnt[i]==0 then pulse_q[i]<=0, else cnt[i]<=cnt[i]-1.
- Retrigger: a PULSE write to a channel already pulsing reloads cnt[i]=PULSE_CYCLES-1. The pulse is extended and no low gap is inserted.
- Level and pulse are ORed: with data_q[i]=1, pulse expiry leaves out_port[i] high.
- Edge capture:
  - done_prev<=done_in every cycle.
  - Rising edge i = done_in[i] & ~done_prev[i]; it sets capture_q[i].
  - done_in high on the first cycle after reset release counts as a rising edge, because done_prev resets to 0.
- Set/clear collision: a rising edge and a W1C on the same bit in the same cycle leaves the bit set (set wins).
- Writes to addr0 and addr1 are independent registers. No write reaches two registers in one cycle, since address selects exactly one.
- Reset mid-pulse: pulse aborts immediately and asynchronously; out_port returns to DATA_RESET.
- No latency on out_port beyond one register stage from the write edge.

Optional Feature:
- Macro: LAYER_CTRL_START_PIO_IRQ_EN.
- Defined:
  - mask_q exists; addr3 is RW.
  - irq = |(capture_q & mask_q), registered: it updates one cycle after capture_q/mask_q change.
- Undefined:
  - No mask register; addr3 reads 0 and writes are ignored.
  - irq tied to 0.
  - Edge capture and STATUS still function for polling.

Test Plan:
- Reset, WIDTH=4, DATA_RESET=0: assert reset_n=0 mid-run -> out_port=0, readdata at addr0/1/2=0, irq=0 immediately.
- Write addr0=0x5, then read -> out_port=0x5, readdata=0x00000005; write 0xFFFFFFF0 -> out_port=0x0, upper bits ignored.
- PULSE_CYCLES=3: write addr1=0x2 -> out_port[1] high exactly 3 cycles, then 0; addr1 reads 0x2 during the pulse and 0x0 after; retrigger on cycle 2 -> total high 5 cycles.
- done_in[3] 0->1 held high -> addr2 reads 0x8 and stays 0x8; W1C write 0x8 in the same cycle as a new rising edge on bit 3 -> still 0x8; W1C with no edge -> 0x0.
- IRQ_EN defined: mask=0x8, capture bit 3 set -> irq=1 one cycle later; clear mask -> irq=0; capture bit 0 with mask 0x8 -> irq stays 0.
- IRQ_EN undefined: write addr3=0xF, rising edge on done_in[0] -> addr3 reads 0, irq stays 0, addr2 reads 0x1.
